// File: rtl/muller_c_pkg.sv
// muller_c_pkg: shared state type, default parameters and width helper for the C-element bank
package muller_c_pkg;

    typedef enum logic {C_LOW, C_HIGH} c_state_t;

    localparam int NCH_DEF       = 2;
    localparam int NIN_DEF       = 3;
    localparam int CNTW_DEF      = 8;
    localparam int STALL_CYC_DEF = 16;

    function automatic int stall_w(input int stall_cyc);
        return $clog2(stall_cyc + 1);
    endfunction

endpackage

// File: rtl/muller_c_channel.sv
// muller_c_channel: one synchronous Muller C-element with toggle pulse, saturating transition count and stall detector
module muller_c_channel
    import muller_c_pkg::*;
#(
    parameter int   NIN       = NIN_DEF,
    parameter int   CNTW      = CNTW_DEF,
    parameter int   STALL_CYC = STALL_CYC_DEF,
    parameter logic INIT      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [NIN-1:0]  in_i,
    input  logic [NIN-1:0]  mask_i,
    input  logic            cnt_clr_i,
    output logic            c_o,
    output logic            toggle_o,
    output logic            stall_o,
    output logic [CNTW-1:0] cnt_o
);

    localparam int              SW      = stall_w(STALL_CYC);
    localparam logic [SW-1:0]   STL_MAX = SW'(STALL_CYC);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    c_state_t        state_q, state_d;
    logic            toggle_q, toggle_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   stl_q, stl_d;
    logic [NIN-1:0]  m_eff;
    logic            rise, fall, unan;

    // A fully masked channel must behave symmetrically, so an all-ones mask is treated as no mask.
    // Evaluation is held off (en_i low) until the synchroniser carries real data after reset.
    always_comb begin
        m_eff    = (&mask_i) ? '0 : mask_i;
        rise     = &in_i;
        fall     = ~|(in_i & ~m_eff);
        unan     = (state_q == C_HIGH) ? ((&(in_i | m_eff)) | fall) : (rise | ~|in_i);
        state_d  = state_q;
        if (en_i && state_q == C_LOW && rise)
            state_d = C_HIGH;
        else if (en_i && state_q == C_HIGH && fall)
            state_d = C_LOW;
        toggle_d = (state_d != state_q);
        cnt_d    = cnt_clr_i ? '0 : (toggle_d && cnt_q != CNT_MAX) ? cnt_q + CNTW'(1) : cnt_q;
        stl_d    = (!en_i || unan) ? '0 : (stl_q == STL_MAX) ? stl_q : stl_q + SW'(1);
    end

    // Channel state, event pulse and both counters; reset forces the initial level with no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_state_t'(INIT);
            toggle_q <= 1'b0;
            cnt_q    <= '0;
            stl_q    <= '0;
        end else begin
            state_q  <= state_d;
            toggle_q <= toggle_d;
            cnt_q    <= cnt_d;
            stl_q    <= stl_d;
        end
    end

    assign c_o      = (state_q == C_HIGH);
    assign toggle_o = toggle_q;
    assign stall_o  = (stl_q == STL_MAX);
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/muller_c_array.sv
// muller_c_array: bank of NCH synchronised NIN-input Muller C-elements; MULLER_C_ASYM_EN adds plus-only input masks
module muller_c_array
    import muller_c_pkg::*;
#(
    parameter int             NCH       = NCH_DEF,
    parameter int             NIN       = NIN_DEF,
    parameter int             CNTW      = CNTW_DEF,
    parameter int             STALL_CYC = STALL_CYC_DEF,
    parameter logic [NCH-1:0] INIT      = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH*NIN-1:0]  io_in,
`ifdef MULLER_C_ASYM_EN
    input  logic [NCH*NIN-1:0]  plus_mask_i,
`endif
    input  logic                cnt_clr_i,
    output logic [NCH-1:0]      c_o,
    output logic [NCH-1:0]      toggle_o,
    output logic [NCH-1:0]      stall_o,
    output logic [NCH*CNTW-1:0] cnt_o
);

    logic [NCH*NIN-1:0] s1_q, s2_q, mask_s;
    logic [1:0]         fill_q;

    // Two-flop synchroniser; fill_q marks when s2 holds post-reset data so no spurious edge is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            fill_q <= '0;
        end else begin
            s1_q   <= io_in;
            s2_q   <= s1_q;
            fill_q <= {fill_q[0], 1'b1};
        end
    end

`ifdef MULLER_C_ASYM_EN
    logic [NCH*NIN-1:0] m1_q, m2_q;

    // The plus-only mask comes from pads too, so it is synchronised exactly like io_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q <= '0;
            m2_q <= '0;
        end else begin
            m1_q <= plus_mask_i;
            m2_q <= m1_q;
        end
    end

    assign mask_s = m2_q;
`else
    assign mask_s = '0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        muller_c_channel #(
            .NIN       (NIN),
            .CNTW      (CNTW),
            .STALL_CYC (STALL_CYC),
            .INIT      (INIT[k])
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (fill_q[1]),
            .in_i      (s2_q[k*NIN +: NIN]),
            .mask_i    (mask_s[k*NIN +: NIN]),
            .cnt_clr_i (cnt_clr_i),
            .c_o       (c_o[k]),
            .toggle_o  (toggle_o[k]),
            .stall_o   (stall_o[k]),
            .cnt_o     (cnt_o[k*CNTW +: CNTW])
        );
    end

endmodule

// File: tb/tb_muller_c_array.sv
// tb_muller_c_array: directed plus random checks of the C-element bank against a sample-history reference model
module tb_muller_c_array;

    localparam int NCH = 2, NIN = 3, CNTW = 4, STC = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       io_in = 6'b111111;
    logic             cnt_clr_i = 1'b0;
    logic [1:0]       c_o, toggle_o, stall_o;
    logic [7:0]       cnt_o;
`ifdef MULLER_C_ASYM_EN
    logic [5:0]       plus_mask_i = 6'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [5:0] hist[$];
    logic       mc[2];
    int         mcnt[2];
    int         run[2];
    logic [1:0] etg;

    muller_c_array #(.NCH(NCH), .NIN(NIN), .CNTW(CNTW), .STALL_CYC(STC), .INIT(2'b00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_in     (io_in),
`ifdef MULLER_C_ASYM_EN
        .plus_mask_i (plus_mask_i),
`endif
        .cnt_clr_i (cnt_clr_i),
        .c_o       (c_o),
        .toggle_o  (toggle_o),
        .stall_o   (stall_o),
        .cnt_o     (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        etg = 2'b00;
        for (int k = 0; k < 2; k++) begin
            mc[k] = 1'b0;
            mcnt[k] = 0;
            run[k] = 0;
        end
    endtask

    // Each channel acts on the io_in value that was present two edges earlier.
    task automatic model_edge(input logic [5:0] smp, input logic clr);
        logic [2:0] b;
        logic       prev;
        hist.push_back(smp);
        if (hist.size() > 3) void'(hist.pop_front());
        etg = 2'b00;
        if (hist.size() == 3) begin
            for (int k = 0; k < 2; k++) begin
                b = hist[0][k*3 +: 3];
                prev = mc[k];
                if (b == 3'b111) mc[k] = 1'b1;
                if (b == 3'b000) mc[k] = 1'b0;
                etg[k] = (mc[k] != prev);
                run[k] = (b == 3'b111 || b == 3'b000) ? 0 : run[k] + 1;
            end
        end
        for (int k = 0; k < 2; k++)
            mcnt[k] = clr ? 0 : mcnt[k] + int'(etg[k]);
    endtask

    function automatic logic [13:0] expected();
        logic [3:0] c1, c0;
        c0 = (mcnt[0] > 15) ? 4'hF : 4'(mcnt[0]);
        c1 = (mcnt[1] > 15) ? 4'hF : 4'(mcnt[1]);
        return {mc[1], mc[0], etg, run[1] >= STC, run[0] >= STC, c1, c0};
    endfunction

    task automatic cmp_model(input string tag);
        checks++;
        assert ({c_o, toggle_o, stall_o, cnt_o} === expected())
        else begin
            errors++;
            $error("FAIL %s t=%0t observed c/tg/st/cnt=%b/%b/%b/%h required %b/%b/%b/%h", tag, $time,
                   c_o, toggle_o, stall_o, cnt_o,
                   expected()[13:12], expected()[11:10], expected()[9:8], expected()[7:0]);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        logic [5:0] smp;
        logic       clr;
        smp = io_in;
        clr = cnt_clr_i;
        @(posedge clk);
        if (rst_n) model_edge(smp, clr);
        #1;
        cmp_model(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Called just after a sampling point; asserts reset between edges and checks its immediate effect.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        cmp_model(tag);
        chk({tag, "_c"}, {6'b0, c_o}, 8'h00);
        chk({tag, "_tg"}, {6'b0, toggle_o}, 8'h00);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset with all inputs high, then release
        steps(3, "rst_hold");
        chk("rst_c", {6'b0, c_o}, 8'h00);
        chk("rst_cnt", cnt_o, 8'h00);
        release_reset();
        steps(2, "rel_fill");
        chk("rel_noc", {6'b0, c_o}, 8'h00);
        step("rel_rise");
        chk("rel_c", {6'b0, c_o}, 8'h03);
        chk("rel_tg", {6'b0, toggle_o}, 8'h03);
        chk("rel_cnt", cnt_o, 8'h11);
        step("rel_after");
        chk("rel_tg_end", {6'b0, toggle_o}, 8'h00);
        // Hysteresis on ch0
        io_in[2:0] = 3'b011;
        steps(5, "hys_011");
        chk("hys_hold1", {7'b0, c_o[0]}, 8'h01);
        io_in[2:0] = 3'b000;
        steps(3, "hys_000");
        chk("hys_fall", {7'b0, c_o[0]}, 8'h00);
        chk("hys_cnt", {4'b0, cnt_o[3:0]}, 8'h02);
        io_in[2:0] = 3'b100;
        steps(5, "hys_100");
        chk("hys_hold0", {7'b0, c_o[0]}, 8'h00);
        // Stall on ch1
        io_in = 6'b101_000;
        steps(5, "stl_pre");
        chk("stl_not_yet", {7'b0, stall_o[1]}, 8'h00);
        step("stl_on");
        chk("stl_on", {7'b0, stall_o[1]}, 8'h01);
        steps(3, "stl_hold");
        io_in[5:3] = 3'b111;
        steps(2, "stl_clr_pre");
        chk("stl_still", {7'b0, stall_o[1]}, 8'h01);
        step("stl_off");
        chk("stl_off", {7'b0, stall_o[1]}, 8'h00);
        chk("stl_c1", {7'b0, c_o[1]}, 8'h01);
        // Saturation on ch0, then clear during a transition
        for (int i = 0; i < 22; i++) begin
            io_in[2:0] = (i % 2) ? 3'b000 : 3'b111;
            step("sat");
        end
        chk("sat_cnt", {4'b0, cnt_o[3:0]}, 8'h0F);
        io_in[2:0] = 3'b111;
        cnt_clr_i = 1'b1;
        step("clr");
        cnt_clr_i = 1'b0;
        chk("clr_tg", {7'b0, toggle_o[0]}, 8'h01);
        chk("clr_cnt", {4'b0, cnt_o[3:0]}, 8'h00);
        // Async reset with both channels high
        io_in = 6'b111111;
        steps(4, "ar_pre");
        chk("ar_pre_c", {6'b0, c_o}, 8'h03);
        async_reset("ar");
        release_reset();
        steps(4, "ar_rel");
        // Randomised phase with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 3))
                    0: io_in[k*3 +: 3] = 3'b000;
                    1: io_in[k*3 +: 3] = 3'b111;
                    2: io_in[k*3 +: 3] = 3'($urandom);
                    default: ;
                endcase
            end
            cnt_clr_i = ($urandom_range(0, 40) == 0);
            if (rst_n && $urandom_range(0, 150) == 0) async_reset("rnd_ar");
            else if (!rst_n && $urandom_range(0, 2) == 0) release_reset();
            step("rnd");
        end
        cnt_clr_i = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
